pic_host_master: RTL and testbench
==================================

// Module: pic_host_master
// PURPOSE
//  CPU-side bus master for the interrupt controller: writes the ICW1..ICW4 init sequence over WR/A0/dataBus,
//  then watches INT and runs the two-pulse INTA acknowledge cycle, capturing the vector from the data bus.
//  Sits between the processor model and the controller pins (WR, RD, A0, INTA, INT, dataBus).
// PARAMETERS
//  STROBE_CYCLES  2  clk cycles WR / INTA held low per pulse (>=1)
//  GAP_CYCLES     2  clk cycles strobes held high between consecutive writes / INTA pulses (>=1)
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  asynchronous, active-high
//  init_start  in   1  1-cycle request: start ICW sequence using icw1..icw4
//  icw1..icw4  in   8  each; init words, sampled on the cycle init_start is accepted
//  int_en      in   1  1 = service INT requests
//  INT         in   1  interrupt request from controller (asynchronous)
//  data_in     in   8  dataBus as driven by controller
//  WR          out  1  active-low write strobe
//  RD          out  1  active-low read strobe (held 1; reserved for OCW reads)
//  A0          out  1  controller address bit
//  INTA        out  1  active-low interrupt acknowledge
//  data_out    out  8  dataBus value driven during writes
//  data_oe     out  1  1 = host drives dataBus
//  busy        out  1  1 whenever FSM not IDLE
//  initialized out  1  set at end of a completed init sequence; cleared by reset/new init_start
//  vector      out  8  last captured vector; holds until next capture
//  vector_vld  out  1  1-cycle pulse when vector updated
// BEHAVIOUR
//  Reset (async): WR=RD=INTA=1, A0=0, data_out=0, data_oe=0, busy=0, initialized=0, vector=0, vector_vld=0,
//   INT synchroniser cleared, FSM->IDLE. Asserting reset mid-pulse releases strobes immediately.
//  INT passes a 2-flop synchroniser (int_s); 2-cycle latency before FSM may react.
//  FSM: IDLE, W_SETUP, W_LOW, W_GAP, A_LOW1, A_GAP, A_LOW2, A_DONE.
//  IDLE: init_start=1 -> latch icw1..4, clear initialized, word index=ICW1, W_SETUP. Else if initialized &
//   int_en & int_s -> A_LOW1. init_start wins when both true same cycle. init_start while busy is ignored.
//  W_SETUP (1 cycle): data_oe=1, data_out=current word, A0 = 0 for ICW1 else 1; WR=1.
//  W_LOW: WR=0 for STROBE_CYCLES; data/A0 stable. Then WR=1 (rising edge = write point), W_GAP.
//  W_GAP: GAP_CYCLES with WR=1, data held; then next word or finish.
//  Word order: ICW1, ICW2, ICW3 only if icw1[1]==0, ICW4 only if icw1[0]==1. After last word: data_oe=0,
//   initialized=1, IDLE. Writes of N words take N*(1+STROBE_CYCLES+GAP_CYCLES) cycles.
//  A_LOW1: data_oe=0, INTA=0 for STROBE_CYCLES (controller latches ISR/clears IRR); A_GAP: INTA=1 GAP_CYCLES.
//  A_LOW2: INTA=0 for STROBE_CYCLES; vector<=data_in on the last low cycle; A_DONE: INTA=1, vector_vld=1
//   for that one cycle, then IDLE. int_s dropping after A_LOW1 starts does not abort the cycle.
//  INT still high on return to IDLE -> new ack cycle begins next cycle (no lost/duplicated requests).
//  int_en low only blocks new ack cycles; an ack in progress completes.
//  data_oe and INTA never both active; WR and INTA never both low.
// TESTING
//  1 icw1=0x13,icw2=0x40,icw4=0x01 (no ICW3): 3 WR pulses, A0=0,1,1, data 0x13,0x40,0x01; initialized=1.
//  2 icw1=0x11 (ICW3+ICW4): 4 WR pulses, order ICW1..ICW4, timing 4*(1+2+2)=20 cycles busy at defaults.
//  3 initialized, INT=1, data_in=0x43 during 2nd INTA: exactly 2 INTA pulses, vector=0x43, vector_vld 1 cycle.
//  4 INT rises same cycle as init_start from IDLE: init sequence runs first, no INTA until initialized.
//  5 reset asserted during W_LOW and during A_LOW2: WR/INTA go 1 same cycle, all outputs at reset values.
//  6 int_en=0 with INT=1: no INTA; int_en->1: ack starts within 1 cycle; INT held: back-to-back ack cycles.

Source files
------------

// File: rtl/pic_host_master.sv
// CPU-side bus master for the interrupt controller: writes the ICW1..ICW4 init
// sequence over WR/A0/data_out, then services INT with a two-pulse INTA acknowledge.
module pic_host_master #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       int_en,
    input  logic       INT,
    input  logic [7:0] data_in,
    output logic       WR,
    output logic       RD,
    output logic       A0,
    output logic       INTA,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       initialized,
    output logic [7:0] vector,
    output logic       vector_vld,
    output logic [2:0] dbg_state_o
);

    localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] STB_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_SETUP = 3'd1,
        S_W_LOW   = 3'd2,
        S_W_GAP   = 3'd3,
        S_A_LOW1  = 3'd4,
        S_A_GAP   = 3'd5,
        S_A_LOW2  = 3'd6,
        S_A_DONE  = 3'd7
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      idx_q;
    logic [3:0][7:0] icw_q;
    logic            wr_q, a0_q, inta_q, oe_q, busy_q, init_q, vld_q;
    logic [7:0]      dout_q, vec_q;
    logic            int_meta_q, int_s_q;
    logic            nxt_vld_d;
    logic [1:0]      nxt_idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
        end
    end

    // Word after idx_q: ICW3 only in cascade mode (icw1[1]==0), ICW4 only if icw1[0]==1.
    always_comb begin
        nxt_vld_d = 1'b0;
        nxt_idx_d = 2'd0;
        case (idx_q)
            2'd0: begin
                nxt_vld_d = 1'b1;
                nxt_idx_d = 2'd1;
            end
            2'd1: begin
                if (!icw_q[0][1]) begin
                    nxt_vld_d = 1'b1;
                    nxt_idx_d = 2'd2;
                end else if (icw_q[0][0]) begin
                    nxt_vld_d = 1'b1;
                    nxt_idx_d = 2'd3;
                end
            end
            2'd2: begin
                if (icw_q[0][0]) begin
                    nxt_vld_d = 1'b1;
                    nxt_idx_d = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            icw_q   <= '0;
            wr_q    <= 1'b1;
            a0_q    <= 1'b0;
            inta_q  <= 1'b1;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            vec_q   <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (init_start) begin
                        icw_q   <= {icw4, icw3, icw2, icw1};
                        init_q  <= 1'b0;
                        idx_q   <= 2'd0;
                        dout_q  <= icw1;
                        a0_q    <= 1'b0;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_W_SETUP;
                    end else if (init_q && int_en && int_s_q) begin
                        oe_q    <= 1'b0;
                        inta_q  <= 1'b0;
                        cnt_q   <= STB_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_A_LOW1;
                    end
                end
                S_W_SETUP: begin
                    wr_q    <= 1'b0;
                    cnt_q   <= STB_LOAD;
                    state_q <= S_W_LOW;
                end
                S_W_LOW: begin
                    if (cnt_q == '0) begin
                        wr_q    <= 1'b1;
                        cnt_q   <= GAP_LOAD;
                        state_q <= S_W_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_W_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (nxt_vld_d) begin
                        idx_q   <= nxt_idx_d;
                        dout_q  <= icw_q[nxt_idx_d];
                        a0_q    <= 1'b1;
                        state_q <= S_W_SETUP;
                    end else begin
                        oe_q    <= 1'b0;
                        init_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_A_LOW1: begin
                    if (cnt_q == '0) begin
                        inta_q  <= 1'b1;
                        cnt_q   <= GAP_LOAD;
                        state_q <= S_A_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_A_GAP: begin
                    if (cnt_q == '0) begin
                        inta_q  <= 1'b0;
                        cnt_q   <= STB_LOAD;
                        state_q <= S_A_LOW2;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_A_LOW2: begin
                    // The controller drives the vector during the second pulse; take it on the last low cycle.
                    if (cnt_q == '0) begin
                        inta_q  <= 1'b1;
                        vec_q   <= data_in;
                        vld_q   <= 1'b1;
                        state_q <= S_A_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_A_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_q    <= 1'b1;
                    inta_q  <= 1'b1;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign WR          = wr_q;
    assign RD          = 1'b1;
    assign A0          = a0_q;
    assign INTA        = inta_q;
    assign data_out    = dout_q;
    assign data_oe     = oe_q;
    assign busy        = busy_q;
    assign initialized = init_q;
    assign vector      = vec_q;
    assign vector_vld  = vld_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pic_host_master.sv
// Bench for pic_host_master: a trace model expands each host operation into the
// per-cycle pin waveform it must produce; one negedge process compares against it.
module tb_pic_host_master;

    localparam int S = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset, init_start, int_en, INT;
    logic [7:0] icw1, icw2, icw3, icw4, data_in, vec_src;
    logic       WR, RD, A0, INTA, data_oe, busy, initialized, vector_vld;
    logic [7:0] data_out, vector;
    logic [2:0] dbg_state, idle_code;

    always #5 clk = ~clk;

    pic_host_master #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .int_en(int_en), .INT(INT), .data_in(data_in),
        .WR(WR), .RD(RD), .A0(A0), .INTA(INTA), .data_out(data_out), .data_oe(data_oe),
        .busy(busy), .initialized(initialized), .vector(vector), .vector_vld(vector_vld),
        .dbg_state_o(dbg_state)
    );

    // Controller model: presents the vector only while INTA is low for the second pulse.
    logic tog;
    always @(negedge INTA or posedge reset) begin
        if (reset) tog <= 1'b0;
        else       tog <= ~tog;
    end
    assign data_in = (!INTA && !tog) ? vec_src : 8'hEE;

    typedef struct packed {
        logic       wr, inta, oe, a0, busy, init, vld;
        logic [7:0] data, vec;
    } exp_t;
    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];

    int   n_cmp = 0, n_err = 0;
    int   wr_falls = 0, inta_falls = 0, vld_cnt = 0, busy_cnt = 0;
    logic prev_wr = 1'b1, prev_inta = 1'b1;
    logic       init_m;
    logic [7:0] vec_m;
    exp_t       cmp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{wr: 1'b1, inta: 1'b1, oe: 1'b0, a0: 1'b0, busy: 1'b0, init: init_m,
              vld: 1'b0, data: 8'h00, vec: vec_m};
        return e;
    endfunction

    task automatic push(input logic wr, inta, oe, a0, bsy, init, vld, input logic [7:0] data, vec);
        exp_t e;
        e = '{wr: wr, inta: inta, oe: oe, a0: a0, busy: bsy, init: init, vld: vld, data: data, vec: vec};
        exp_q.push_back(EW'(e));
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(EW'(idle_exp()));
    endtask

    // One write = setup cycle, S low cycles, G high cycles; A0 low only for ICW1.
    task automatic push_writes(input logic [7:0] w1, w2, w3, w4, output int nwords);
        logic [7:0] ws[$];
        ws.push_back(w1);
        ws.push_back(w2);
        if (!w1[1]) ws.push_back(w3);
        if (w1[0])  ws.push_back(w4);
        foreach (ws[i]) begin
            push(1'b1, 1'b1, 1'b1, i != 0, 1'b1, 1'b0, 1'b0, ws[i], vec_m);
            repeat (S) push(1'b0, 1'b1, 1'b1, i != 0, 1'b1, 1'b0, 1'b0, ws[i], vec_m);
            repeat (G) push(1'b1, 1'b1, 1'b1, i != 0, 1'b1, 1'b0, 1'b0, ws[i], vec_m);
        end
        init_m = 1'b1;
        nwords = ws.size();
    endtask

    task automatic push_ack(input logic [7:0] v);
        repeat (S) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, init_m, 1'b0, 8'h00, vec_m);
        repeat (G) push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, init_m, 1'b0, 8'h00, vec_m);
        repeat (S) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, init_m, 1'b0, 8'h00, vec_m);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, init_m, 1'b1, 8'h00, v);
        vec_m = v;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_wr   = 1'b1;
            prev_inta = 1'b1;
        end else begin
            if (exp_q.size() > 0) cmp_e = exp_t'(exp_q.pop_front());
            else                  cmp_e = idle_exp();
            chk("WR", WR, cmp_e.wr);
            chk("RD", RD, 1'b1);
            chk("INTA", INTA, cmp_e.inta);
            chk("data_oe", data_oe, cmp_e.oe);
            chk("busy", busy, cmp_e.busy);
            chk("initialized", initialized, cmp_e.init);
            chk("vector", vector, cmp_e.vec);
            chk("vector_vld", vector_vld, cmp_e.vld);
            chk("dbg_state_idle", dbg_state == idle_code, !cmp_e.busy);
            if (cmp_e.oe) begin
                chk("data_out", data_out, cmp_e.data);
                chk("A0", A0, cmp_e.a0);
            end
            chk("wr_inta_excl", !WR && !INTA, 1'b0);
            chk("oe_inta_excl", data_oe && !INTA, 1'b0);
            if (prev_wr && !WR)     wr_falls++;
            if (prev_inta && !INTA) inta_falls++;
            if (vector_vld)         vld_cnt++;
            if (busy)               busy_cnt++;
            prev_wr   = WR;
            prev_inta = INTA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_falls = 0; inta_falls = 0; vld_cnt = 0; busy_cnt = 0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_WR"}, WR, 1'b1);
        chk({tag, "_RD"}, RD, 1'b1);
        chk({tag, "_INTA"}, INTA, 1'b1);
        chk({tag, "_A0"}, A0, 1'b0);
        chk({tag, "_data_out"}, data_out, 8'h00);
        chk({tag, "_data_oe"}, data_oe, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_initialized"}, initialized, 1'b0);
        chk({tag, "_vector"}, vector, 8'h00);
        chk({tag, "_vector_vld"}, vector_vld, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        exp_q.delete();
        init_m = 1'b0;
        vec_m  = 8'h00;
        INT    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_init(input logic [7:0] a, b, c, d, output int n);
        icw1 = a; icw2 = b; icw3 = c; icw4 = d;
        init_start = 1'b1;
        tick();
        push_writes(a, b, c, d, n);
        init_start = 1'b0;
        icw1 = 8'hFF; icw2 = 8'hFF; icw3 = 8'hFF; icw4 = 8'hFF;
        drain(200);
    endtask

    initial begin
        int n;
        reset = 1'b1; init_start = 1'b0; int_en = 1'b0; INT = 1'b0;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; vec_src = 8'h00;
        init_m = 1'b0; vec_m = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        idle_code = dbg_state;
        check_reset_vals("por");
        reset = 1'b0;
        repeat (2) tick();

        // 1: single PIC with ICW4, no ICW3
        clear_counts();
        do_init(8'h13, 8'h40, 8'hAA, 8'h01, n);
        chk("t1_words", n, 3);
        chk("t1_wr_pulses", wr_falls, 3);
        chk("t1_busy_cycles", busy_cnt, 15);
        chk("t1_initialized", initialized, 1'b1);

        // 2: cascade with ICW3 and ICW4
        clear_counts();
        do_init(8'h11, 8'h48, 8'h04, 8'h03, n);
        chk("t2_wr_pulses", wr_falls, 4);
        chk("t2_busy_cycles", busy_cnt, 20);

        // 3: one acknowledge cycle
        clear_counts();
        vec_src = 8'h43; int_en = 1'b1; INT = 1'b1;
        repeat (3) tick();
        push_ack(8'h43);
        INT = 1'b0;
        drain(100);
        repeat (3) tick();
        chk("t3_inta_pulses", inta_falls, 2);
        chk("t3_vld_pulses", vld_cnt, 1);
        chk("t3_vector", vector, 8'h43);

        // 4: init_start beats a pending synchronised INT; ack follows the init
        clear_counts();
        int_en = 1'b0; INT = 1'b1; vec_src = 8'h21;
        repeat (4) tick();
        icw1 = 8'h13; icw2 = 8'h50; icw3 = 8'h00; icw4 = 8'h01;
        init_start = 1'b1; int_en = 1'b1;
        tick();
        push_writes(8'h13, 8'h50, 8'h00, 8'h01, n);
        push_idle(1);
        push_ack(8'h21);
        init_start = 1'b0;
        repeat (n * (1 + S + G) + 1) tick();
        INT = 1'b0;
        drain(100);
        chk("t4_wr_pulses", wr_falls, 3);
        chk("t4_inta_pulses", inta_falls, 2);
        chk("t4_vector", vector, 8'h21);

        // 6: int_en gating, back-to-back acks, int_en drop mid-ack
        clear_counts();
        int_en = 1'b0; INT = 1'b1; vec_src = 8'h5A;
        repeat (6) tick();
        chk("t6_no_inta_disabled", inta_falls, 0);
        int_en = 1'b1;
        tick();
        push_ack(8'h5A);
        push_idle(1);
        push_ack(8'hA5);
        repeat (8) tick();
        vec_src = 8'hA5; int_en = 1'b0;
        drain(100);
        repeat (4) tick();
        chk("t6_inta_pulses", inta_falls, 4);
        chk("t6_vld_pulses", vld_cnt, 2);
        chk("t6_vector", vector, 8'hA5);
        INT = 1'b0;
        tick();

        // 5a: reset during a WR low pulse
        icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h01;
        init_start = 1'b1;
        tick();
        push_writes(8'h13, 8'h40, 8'h00, 8'h01, n);
        init_start = 1'b0;
        tick();
        chk("t5a_wr_low", WR, 1'b0);
        async_reset("t5a");
        repeat (3) tick();

        // 5b: two-word init (no ICW3/ICW4), then reset during the second INTA pulse
        clear_counts();
        do_init(8'h12, 8'h60, 8'h00, 8'h00, n);
        chk("t5b_wr_pulses", wr_falls, 2);
        vec_src = 8'h77; int_en = 1'b1; INT = 1'b1;
        repeat (3) tick();
        push_ack(8'h77);
        INT = 1'b0;
        repeat (4) tick();
        chk("t5b_inta_low2", INTA, 1'b0);
        async_reset("t5b");
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
